rl_frame_sequencer: RTL and testbench

Sequences one acquisition frame of the ear-EEG front-end read/load interface. On each frame request it issues a burst of LOAD_G strobes, switches the front-end to read state, and clocks N_CH words of W bits in serially with fdata_G strobes. Each word goes to the downstream packer over a valid/ready handshake; the block then returns the front-end to load state. It sits between the sample-rate timer and the front-end read/load control logic in fpga_sys.

---
 rtl/rl_frame_sequencer_pkg.sv | 19 +
 rtl/rl_frame_sequencer_if.sv | 30 +++
 rtl/rl_frame_sequencer_slot_timer.sv | 38 +++
 rtl/rl_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rl_frame_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rl_frame_sequencer_pkg.sv
// Shared types and helpers for the ear-EEG read/load frame sequencer.
package rl_frame_sequencer_pkg;

   // Frame sequencing states; busy is high in every state except ST_IDLE.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_TO_READ = 3'd2,
      ST_READ    = 3'd3,
      ST_HOLD    = 3'd4,
      ST_TO_LOAD = 3'd5
   } state_e;

   // Counter/index width for a range of n values, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rl_frame_sequencer_if.sv
// Channel-word handshake between the sequencer and the downstream packer.
interface rl_frame_sequencer_if
   import rl_frame_sequencer_pkg::*;
#(
   parameter int unsigned N_CH = 8,
   parameter int unsigned W    = 16
);
   localparam int unsigned CH_W = width_of(N_CH);

   logic [W-1:0]    word_out;
   logic [CH_W-1:0] ch_idx;
   logic            word_valid;
   logic            word_ready;

   // Sequencer side: presents words and waits for acceptance.
   modport master (
      output word_out,
      output ch_idx,
      output word_valid,
      input  word_ready
   );

   // Packer side: consumes words.
   modport slave (
      input  word_out,
      input  ch_idx,
      input  word_valid,
      output word_ready
   );
endinterface

// File: rtl/rl_frame_sequencer_slot_timer.sv
// GAP-cycle slot counter. While restart_i is high the count is parked at 0,
// so the first cycle after restart_i drops is always the first cycle of a slot.
module rl_frame_sequencer_slot_timer
   import rl_frame_sequencer_pkg::*;
#(
   parameter int unsigned GAP = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart_i,
   output logic slot_first_o,
   output logic slot_last_o
);
   localparam int unsigned CW = width_of(GAP);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: park on restart, otherwise count 0..GAP-1 and wrap.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || (cnt_q == CW'(GAP - 1))) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign slot_first_o = (cnt_q == '0);
   assign slot_last_o  = (cnt_q == CW'(GAP - 1));
endmodule

// File: rtl/rl_frame_sequencer.sv
// Frame sequencer for the ear-EEG front-end: LOAD_G burst, switch to read,
// shift in N_CH serial words (MSB first), hand each one downstream, then
// return the front-end to load state.
module rl_frame_sequencer
   import rl_frame_sequencer_pkg::*;
#(
   parameter int unsigned N_CH   = 8,
   parameter int unsigned W      = 16,
   parameter int unsigned N_LOAD = 7,
   parameter int unsigned GAP    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic frame_tick,
   input  logic clear,
   input  logic sdata_in,
   output logic LOAD_G,
   output logic fdata_G,
   output logic R_L_con,
   output logic busy,
   output logic overrun,
   rl_frame_sequencer_if.master word_if
);
   localparam int unsigned CH_W     = width_of(N_CH);
   localparam int unsigned SLOT_MAX = (N_LOAD > W) ? N_LOAD : W;
   localparam int unsigned SC_W     = width_of(SLOT_MAX);

   state_e          state_q;
   logic [SC_W-1:0] slot_q;
   logic            load_g_q;
   logic            fdata_q;
   logic            rl_q;
   logic [W-1:0]    shift_q;
   logic [W-1:0]    word_q;
   logic [CH_W-1:0] ch_q;
   logic            valid_q;
   logic            overrun_q;

   logic slot_first;
   logic slot_last;
   logic restart;

   // The timer is held at slot start while waiting for a frame or for the
   // packer; every other state is entered exactly on a slot boundary.
   assign restart = (state_q == ST_IDLE) || (state_q == ST_HOLD);

   rl_frame_sequencer_slot_timer #(
      .GAP (GAP)
   ) u_slot_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .restart_i    (restart),
      .slot_first_o (slot_first),
      .slot_last_o  (slot_last)
   );

   // Frame FSM; strobes are registered and set one cycle ahead of the slot
   // cycle in which they must appear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         slot_q   <= '0;
         load_g_q <= 1'b0;
         fdata_q  <= 1'b0;
         rl_q     <= 1'b1;
         shift_q  <= '0;
         word_q   <= '0;
         ch_q     <= '0;
         valid_q  <= 1'b0;
      end else begin
         load_g_q <= 1'b0;
         fdata_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (frame_tick && enable) begin
                  state_q  <= ST_LOAD;
                  slot_q   <= '0;
                  load_g_q <= 1'b1;
                  rl_q     <= 1'b1;
                  ch_q     <= '0;
               end
            end
            ST_LOAD: begin
               if (slot_last) begin
                  if (slot_q == SC_W'(N_LOAD - 1)) begin
                     state_q <= ST_TO_READ;
                     fdata_q <= 1'b1;
                     rl_q    <= 1'b0;
                  end else begin
                     slot_q   <= slot_q + SC_W'(1);
                     load_g_q <= 1'b1;
                  end
               end
            end
            ST_TO_READ: begin
               if (slot_last) begin
                  state_q <= ST_READ;
                  slot_q  <= '0;
                  fdata_q <= 1'b1;
               end
            end
            ST_READ: begin
               // Sample at the end of the slot, giving the front-end the
               // whole slot to settle after its fdata_G strobe.
               if (slot_last) begin
                  shift_q <= {shift_q[W-2:0], sdata_in};
                  if (slot_q == SC_W'(W - 1)) begin
                     state_q <= ST_HOLD;
                     word_q  <= {shift_q[W-2:0], sdata_in};
                     valid_q <= 1'b1;
                  end else begin
                     slot_q  <= slot_q + SC_W'(1);
                     fdata_q <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // The timer is parked at slot start here, so leaving HOLD
               // always lines the next slot up with the strobe.
               if (word_if.word_ready && slot_first) begin
                  valid_q <= 1'b0;
                  slot_q  <= '0;
                  fdata_q <= 1'b1;
                  if (ch_q == CH_W'(N_CH - 1)) begin
                     state_q <= ST_TO_LOAD;
                     rl_q    <= 1'b1;
                  end else begin
                     state_q <= ST_READ;
                     ch_q    <= ch_q + CH_W'(1);
                  end
               end
            end
            ST_TO_LOAD: begin
               if (slot_last) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Sticky overrun: a request that cannot be served; a new event beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (frame_tick && ((state_q != ST_IDLE) || !enable)) begin
         overrun_q <= 1'b1;
      end else if (clear) begin
         overrun_q <= 1'b0;
      end
   end

   assign LOAD_G             = load_g_q;
   assign fdata_G            = fdata_q;
   assign R_L_con            = rl_q;
   assign busy               = (state_q != ST_IDLE);
   assign overrun            = overrun_q;
   assign word_if.word_out   = word_q;
   assign word_if.ch_idx     = ch_q;
   assign word_if.word_valid = valid_q;
endmodule

// File: tb/tb_rl_frame_sequencer.sv
// Self-checking bench for rl_frame_sequencer: a front-end model serialises
// chosen channel words, a scoreboard checks the words handed downstream,
// and per-frame timing is checked against the frame timing formulas.
module tb_rl_frame_sequencer;
   localparam int N_CH   = 2;
   localparam int W      = 4;
   localparam int N_LOAD = 7;
   localparam int GAP    = 4;

   typedef struct {
      int ch;
      int word;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b1;
   logic frame_tick = 1'b0;
   logic clear = 1'b0;
   logic sdata_in = 1'b0;
   logic LOAD_G, fdata_G, R_L_con, busy, overrun;

   rl_frame_sequencer_if #(.N_CH(N_CH), .W(W)) wif ();

   rl_frame_sequencer #(
      .N_CH   (N_CH),
      .W      (W),
      .N_LOAD (N_LOAD),
      .GAP    (GAP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .frame_tick (frame_tick),
      .clear      (clear),
      .sdata_in   (sdata_in),
      .LOAD_G     (LOAD_G),
      .fdata_G    (fdata_G),
      .R_L_con    (R_L_con),
      .busy       (busy),
      .overrun    (overrun),
      .word_if    (wif)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   exp_t exp_q[$];

   logic [W-1:0] fe_words [N_CH];
   int fe_cnt = 0;
   int stall_plan [N_CH];
   int stall_left = 0;
   bit in_hold = 0;

   // per-frame observations
   int st_busy_len, st_first_busy, st_load_cnt, st_first_load, st_last_load;
   int st_load_gap_bad, st_fdata_cnt, st_first_fdata, st_first_valid;
   int st_valid_cnt, st_overlap, st_hold_bad;
   int load_total = 0;
   int fdata_total = 0;
   bit prev_valid = 0;
   bit prev_hs = 0;
   logic [W-1:0] prev_word;
   int prev_ch;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic reset_stats();
      st_busy_len = 0; st_first_busy = -1; st_load_cnt = 0; st_first_load = -1;
      st_last_load = -1; st_load_gap_bad = 0; st_fdata_cnt = 0; st_first_fdata = -1;
      st_first_valid = -1; st_valid_cnt = 0; st_overlap = 0; st_hold_bad = 0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Front-end model: after the read-state strobe, each further fdata_G
   // strobe in read state clocks out the next bit, MSB first, channel by channel.
   always @(posedge clk) begin
      #1;
      if (!rst_n || R_L_con) begin
         fe_cnt = 0;
      end else if (fdata_G) begin
         fe_cnt++;
         if (fe_cnt >= 2 && (fe_cnt - 2) < N_CH * W) begin
            sdata_in = fe_words[(fe_cnt - 2) / W][W - 1 - ((fe_cnt - 2) % W)];
         end
      end
   end

   // Packer model: stalls each word by its planned number of cycles.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         wif.word_ready = 1'b1;
         in_hold = 0;
      end else if (wif.word_valid) begin
         if (!in_hold) begin
            in_hold = 1;
            stall_left = (int'(wif.ch_idx) < N_CH) ? stall_plan[int'(wif.ch_idx)] : 0;
         end
         if (stall_left > 0) begin
            wif.word_ready = 1'b0;
            stall_left--;
         end else begin
            wif.word_ready = 1'b1;
         end
      end else begin
         in_hold = 0;
         wif.word_ready = 1'b1;
      end
   end

   // Scoreboard monitor: every accepted word must match the next expected one.
   always @(negedge clk) begin : sb_mon
      exp_t e;
      if (rst_n && wif.word_valid && wif.word_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_ch_idx", int'(wif.ch_idx), e.ch);
            check("sb_word_out", int'(wif.word_out), e.word);
         end
      end
   end

   // Timing monitor: strobe positions, busy length and HOLD stability.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) begin
            st_busy_len++;
            if (st_first_busy < 0) st_first_busy = cyc;
         end
         if (LOAD_G) begin
            st_load_cnt++;
            load_total++;
            if (st_first_load < 0) st_first_load = cyc;
            else if (cyc - st_last_load != GAP) st_load_gap_bad++;
            st_last_load = cyc;
         end
         if (fdata_G) begin
            st_fdata_cnt++;
            fdata_total++;
            if (st_first_fdata < 0) st_first_fdata = cyc;
         end
         if (LOAD_G && fdata_G) st_overlap++;
         if (wif.word_valid) begin
            st_valid_cnt++;
            if (st_first_valid < 0) st_first_valid = cyc;
            if (LOAD_G || fdata_G) st_hold_bad++;
            if (prev_valid && !prev_hs &&
                (wif.word_out != prev_word || int'(wif.ch_idx) != prev_ch)) st_hold_bad++;
         end
         prev_valid = wif.word_valid;
         prev_hs = wif.word_valid && wif.word_ready;
         prev_word = wif.word_out;
         prev_ch = int'(wif.ch_idx);
      end else begin
         prev_valid = 0;
      end
   end

   // One complete frame, entered and left just after a rising edge; it
   // returns in the first IDLE cycle so a following frame can start there.
   task automatic run_frame(input string tag, input logic [W-1:0] words [N_CH],
                            input int stalls [N_CH], input int mid_k, input bit mid_clear);
      int tick_cyc, k, total_stall;
      bit done;
      total_stall = 0;
      for (int i = 0; i < N_CH; i++) begin
         exp_q.push_back('{ch: i, word: int'(words[i])});
         fe_words[i] = words[i];
         stall_plan[i] = stalls[i];
         total_stall += stalls[i];
      end
      reset_stats();
      tick_cyc = cyc;
      frame_tick = 1'b1;
      k = 0;
      done = 0;
      while (!done && k < 3000) begin
         @(posedge clk); #1;
         k++;
         frame_tick = (mid_k != 0) && (k == mid_k);
         clear = mid_clear && (k == mid_k);
         if (!busy) done = 1;
      end
      frame_tick = 1'b0;
      clear = 1'b0;
      check({tag, " frame_done"}, int'(done), 1);
      check({tag, " first_busy"}, st_first_busy, tick_cyc + 1);
      check({tag, " first_load"}, st_first_load, tick_cyc + 1);
      check({tag, " load_cnt"}, st_load_cnt, N_LOAD);
      check({tag, " load_spacing"}, st_load_gap_bad, 0);
      check({tag, " first_fdata"}, st_first_fdata, tick_cyc + 1 + N_LOAD * GAP);
      check({tag, " fdata_cnt"}, st_fdata_cnt, N_CH * W + 2);
      check({tag, " first_valid"}, st_first_valid, tick_cyc + 1 + (N_LOAD + 1 + W) * GAP);
      check({tag, " busy_len"}, st_busy_len,
            (N_LOAD + 2 + N_CH * W) * GAP + N_CH + total_stall);
      check({tag, " strobe_overlap"}, st_overlap, 0);
      check({tag, " hold_stable"}, st_hold_bad, 0);
      check({tag, " overrun"}, int'(overrun), int'(mid_k != 0));
      check({tag, " R_L_con_end"}, int'(R_L_con), 1);
      check({tag, " words_left"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [W-1:0] words [N_CH];
      int stalls [N_CH];
      int abort_tick;

      wif.word_ready = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
         stall_plan[i] = 0;
         fe_words[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset.
      repeat (20) @(posedge clk);
      #1;
      check("idle LOAD_G_pulses", load_total, 0);
      check("idle fdata_G_pulses", fdata_total, 0);
      check("idle R_L_con", int'(R_L_con), 1);
      check("idle busy", int'(busy), 0);
      check("idle overrun", int'(overrun), 0);
      check("idle word_valid", int'(wif.word_valid), 0);
      check("idle word_out", int'(wif.word_out), 0);
      check("idle ch_idx", int'(wif.ch_idx), 0);

      // Basic frame: 1010 then 0111, no stalls.
      words[0] = 4'hA;
      words[1] = 4'h7;
      for (int i = 0; i < N_CH; i++) stalls[i] = 0;
      run_frame("basic", words, stalls, 0, 0);

      // Back-to-back frame in the first IDLE cycle, first word stalled 10 cycles.
      stalls[0] = 10;
      run_frame("stall", words, stalls, 0, 0);
      stalls[0] = 0;

      // frame_tick during READ: overrun set, frame unchanged, then clear.
      words[0] = 4'h3;
      words[1] = 4'hC;
      run_frame("tick_in_read", words, stalls, (N_LOAD + 1) * GAP + 3, 0);
      check("overrun_held", int'(overrun), 1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("overrun_cleared", int'(overrun), 0);

      // Overrun event with simultaneous clear: the set wins.
      run_frame("tick_with_clear", words, stalls, (N_LOAD + 2) * GAP + 1, 1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("overrun_cleared2", int'(overrun), 0);

      // Reset during READ bit 2: everything back to reset values at once.
      words[0] = 4'h5;
      words[1] = 4'h9;
      for (int i = 0; i < N_CH; i++) fe_words[i] = words[i];
      reset_stats();
      abort_tick = cyc;
      frame_tick = 1'b1;
      repeat (1 + (N_LOAD + 1) * GAP + 2 * GAP + 1) begin
         @(posedge clk); #1;
         frame_tick = 1'b0;
      end
      check("abort busy_before", int'(busy), 1);
      check("abort cycle", cyc - abort_tick, 1 + (N_LOAD + 3) * GAP + 1);
      rst_n = 1'b0;
      #1;
      check("abort LOAD_G", int'(LOAD_G), 0);
      check("abort fdata_G", int'(fdata_G), 0);
      check("abort R_L_con", int'(R_L_con), 1);
      check("abort busy", int'(busy), 0);
      check("abort word_valid", int'(wif.word_valid), 0);
      check("abort word_out", int'(wif.word_out), 0);
      check("abort ch_idx", int'(wif.ch_idx), 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("abort no_word_valid", st_valid_cnt, 0);
      run_frame("after_reset", words, stalls, 0, 0);

      // frame_tick while disabled: stays idle, overrun set.
      enable = 1'b0;
      reset_stats();
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("disabled busy", int'(busy), 0);
      check("disabled overrun", int'(overrun), 1);
      check("disabled LOAD_G_pulses", st_load_cnt, 0);
      enable = 1'b1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("disabled overrun_cleared", int'(overrun), 0);

      // Random frames with random words, stalls and idle gaps.
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < N_CH; i++) begin
            words[i] = W'($urandom);
            stalls[i] = int'($urandom_range(0, 3));
         end
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         run_frame($sformatf("rand%0d", f), words, stalls, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
